// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   state_t : controller state encoding (IDLE, RUN).
package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Request/result bundle for serial_adder.
//   start, a, b           : request side, driven by the master
//   busy, done, sum, cout : status/result side, driven by the adder (slave)
interface serial_adder_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         cout;

   modport master (
      output start, a, b,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   One-bit full adder built from two half-adder stages and an OR.
//   a, b, cin : addend bits and carry in
//   s, co     : sum bit and carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);
   logic p1;
   logic g1;
   logic g2;

   // first half adder: a + b
   assign p1 = a ^ b;
   assign g1 = a & b;

   // second half adder: partial sum + cin
   assign s  = p1 ^ cin;
   assign g2 = p1 & cin;

   assign co = g1 | g2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial N-bit unsigned adder, LSB first, one bit per clock through a
//   single full_adder with the carry held in a flip-flop. Result is loaded in
//   parallel with a one-cycle done pulse, N clocks after the accepted start.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (start/a/b in, busy/done/sum/cout out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; sum/cout hold the last completed result
//   RUN   | one bit per edge; completion edge loads sum/cout, pulses done
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_adder_if.slave   bus
);
   localparam int              CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state;
   logic [N-1:0]     sa;
   logic [N-1:0]     sb;
   logic [N-1:0]     sum_q;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;
   logic             fa_s;
   logic             fa_co;

   full_adder u_fa (
      .a   (sa[0]),
      .b   (sb[0]),
      .cin (carry),
      .s   (fa_s),
      .co  (fa_co)
   );

   // The bit of sa consumed each edge frees its MSB, so sa doubles as the
   // sum shift register: after N shifts it holds the completed sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sum_q  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= bus.b;
                  carry  <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sa    <= {fa_s, sa[N-1:1]};
               sb    <= {1'b0, sb[N-1:1]};
               carry <= fa_co;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum_q  <= {fa_s, sa[N-1:1]};
                  cout_q <= fa_co;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  cnt    <= '0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Scoreboard bench for serial_adder at N=8 (directed cases + sweep) and
//   N=16 (sweep). Drivers push expected {cout,sum} and due cycle into queues;
//   per-instance monitors pop and compare on every done pulse.
module tb_serial_adder;
   localparam int N8  = 8;
   localparam int N16 = 16;

   typedef struct {
      logic [16:0] res;
      int unsigned due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned cyc = 0;
   int n_pass = 0;
   int n_total = 0;

   exp_t q8[$];
   exp_t q16[$];
   exp_t e8;
   exp_t e16;

   serial_adder_if #(.N(N8))  if8 ();
   serial_adder_if #(.N(N16)) if16 ();

   serial_adder #(.N(N8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8)
   );

   serial_adder #(.N(N16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // monitors
   always @(negedge clk) begin
      if (rst_n && if8.done) begin
         if (q8.size() == 0) check("n8_unexpected_done", 64'd1, 64'd0);
         else begin
            e8 = q8.pop_front();
            check("n8_result", {if8.cout, if8.sum}, e8.res);
            check("n8_latency", cyc, e8.due);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if16.done) begin
         if (q16.size() == 0) check("n16_unexpected_done", 64'd1, 64'd0);
         else begin
            e16 = q16.pop_front();
            check("n16_result", {if16.cout, if16.sum}, e16.res);
            check("n16_latency", cyc, e16.due);
         end
      end
   end

   // drivers: call just before a rising edge; start is dropped after it
   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input bit track);
      bit idle;
      idle = !if8.busy;
      if8.start = 1'b1;
      if8.a = a;
      if8.b = b;
      @(posedge clk);
      #1;
      if (idle && track) q8.push_back('{res: 17'(a) + 17'(b), due: cyc + N8});
      if8.start = 1'b0;
   endtask

   task automatic drive16(input logic [15:0] a, input logic [15:0] b);
      bit idle;
      idle = !if16.busy;
      if16.start = 1'b1;
      if16.a = a;
      if16.b = b;
      @(posedge clk);
      #1;
      if (idle) q16.push_back('{res: 17'(a) + 17'(b), due: cyc + N16});
      if16.start = 1'b0;
   endtask

   // returns at the negedge where done is seen
   task automatic wait_done8(output int busy_cycles);
      bit seen;
      seen = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (if8.done) seen = 1'b1;
         else if (if8.busy) busy_cycles++;
      end
      if (!seen) check("n8_done_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_done16;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (if16.done) seen = 1'b1;
      end
      if (!seen) check("n16_done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bc;
      int viol;
      int dones;

      if8.start = 1'b0;
      if8.a = '0;
      if8.b = '0;
      if16.start = 1'b0;
      if16.a = '0;
      if16.b = '0;

      #1;
      check("reset_busy", if8.busy, 0);
      check("reset_done", if8.done, 0);
      check("reset_sum",  if8.sum,  0);
      check("reset_cout", if8.cout, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic 100 + 27
      @(negedge clk);
      drive8(8'd100, 8'd27, 1'b1);
      wait_done8(bc);
      check("basic_busy_cycles", bc, 8);
      check("basic_busy_low_at_done", if8.busy, 0);

      // carry out, then zero
      @(negedge clk);
      drive8(8'd255, 8'd1, 1'b1);
      wait_done8(bc);
      @(negedge clk);
      drive8(8'd0, 8'd0, 1'b1);
      wait_done8(bc);

      // start while busy is ignored
      @(negedge clk);
      drive8(8'd10, 8'd20, 1'b1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      drive8(8'd200, 8'd200, 1'b1);
      wait_done8(bc);
      repeat (N8 + 4) @(negedge clk);

      // back-to-back: second start in the done cycle
      @(negedge clk);
      drive8(8'd5, 8'd6, 1'b1);
      wait_done8(bc);
      drive8(8'd128, 8'd128, 1'b1);
      viol = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (if8.done) break;
         if (if8.sum !== 8'd11 || if8.cout !== 1'b0) viol++;
      end
      check("b2b_result_hold", viol, 0);

      // reset mid-operation
      @(negedge clk);
      drive8(8'd200, 8'd100, 1'b0);
      repeat (4) @(negedge clk);
      check("midop_busy_before_reset", if8.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midop_reset_busy", if8.busy, 0);
      check("midop_reset_done", if8.done, 0);
      check("midop_reset_sum",  if8.sum,  0);
      check("midop_reset_cout", if8.cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      repeat (N8 + 4) begin
         @(negedge clk);
         if (if8.done) dones++;
      end
      check("midop_no_done", dones, 0);
      @(negedge clk);
      drive8(8'd1, 8'd2, 1'b1);
      wait_done8(bc);

      // random sweeps
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               @(negedge clk);
               drive8(8'($urandom), 8'($urandom), 1'b1);
               wait_done8(bc);
            end
         end
         begin
            for (int j = 0; j < 1000; j++) begin
               @(negedge clk);
               drive16(16'($urandom), 16'($urandom));
               wait_done16();
            end
         end
      join

      repeat (2) @(negedge clk);
      check("n8_queue_empty",  q8.size(),  0);
      check("n16_queue_empty", q16.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB first. It is the add-direction counterpart of the team's subtractor cells.
- Operands load in parallel on a start request. One bit is processed per clock through a single full-adder cell, with the carry held in a flip-flop.
- Result is presented in parallel with a one-cycle done pulse.
- Used where area matters more than latency; complements the combinational adder and subtractor blocks.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only when not busy.
- a  input  N  operand A; captured on the accepted start edge.
- b  input  N  operand B; captured on the accepted start edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum/cout valid from this cycle onward.
- sum  output  N  registered result, (a+b) mod 2^N.
- cout  output  1  registered carry out of bit N-1.

Behaviour:
- Reset (rst_n low, asynchronous, any time): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry FF=0, operand shift registers=0.
  - Reset mid-operation abandons the addition.
  - No done pulse is generated.
  - sum and cout read 0 after reset.
- States: IDLE, RUN. There is no separate DONE state; done is a registered pulse.
- IDLE:
  - start=1 at a clock edge → capture a and b into shift registers sa and sb, clear carry FF, counter=0, go to RUN. busy=1 from the cycle after that edge.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - Compute s = sa[0]^sb[0]^c and c' = majority(sa[0], sb[0], c).
  - Shift s into the MSB of an internal sum shift register; shift sa and sb right by 1; carry FF=c'; counter+1.
- The edge that processes bit N-1 (counter==N-1):
  - Load sum from the completed shift value and cout=c'.
  - Set done=1 for exactly the next cycle; busy=0; go to IDLE.
- Latency: a start accepted at edge k gives done high in the cycle after edge k+N. Exactly N RUN edges.
- start while busy=1 is ignored. Operands are not re-captured and there is no queuing.
- Back-to-back: start high in the done cycle is accepted, since state is already IDLE. The new run does not disturb sum/cout until its own completion edge.
- sum and cout hold their last completed value until the next completion or reset. The outputs never show partial results.
- a and b may change freely after the capture edge.
- Arithmetic: unsigned. Two's-complement users take sum directly and ignore cout; overflow detection is out of scope.
- The counter is ceil(log2(N)) bits wide and compares against N-1. There is no wrap beyond N-1.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN). No other typedefs are needed.
- One sub-module, full_adder (inputs a, b, cin; outputs s, co), built from two half-adder stages plus an OR.
- serial_adder instantiates full_adder once. Control, counter and shift registers live in the top.

Test Plan:
- Basic: N=8, a=100, b=27, pulse start → busy=1 for 8 cycles; done pulses once in cycle 9 after start; sum=127, cout=0.
- Carry out: a=255, b=1 → sum=0, cout=1. Then a=0, b=0 → sum=0, cout=0.
- Start while busy: start at t0 (a=10, b=20), then start again at t0+3 with a=200, b=200 → single done; sum=30, cout=0.
- Back-to-back: first op 5+6; hold start high into the done cycle with a=128, b=128 → sum stays 11 until the second done, which comes N cycles later with sum=0, cout=1.
- Reset mid-op: start 200+100, assert rst_n=0 at cycle 4 → busy, done, sum and cout all go to 0 immediately, and no done pulse follows. After release, 1+2 gives sum=3.
- Random sweep: 1000 random a/b pairs, N=8 and N=16 → {cout,sum} equals a+b, and each done arrives exactly N cycles after its accepted start.
